// File: rtl/step_debouncer.sv
// Step push-button debouncer: two-flop synchronizer plus a tick-counting FSM
// that produces a clean level and a one-clock rising pulse. Defining
// STEP_DEBOUNCER_FALL_EN adds a matching falling-edge pulse output db_fall_tick.
module step_debouncer #(
    parameter int N_TICKS = 3,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db_level,
`ifdef STEP_DEBOUNCER_FALL_EN
    output logic db_fall_tick,
`endif
    output logic db_tick
);

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N_TICKS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s1;
    logic          s_sync;

    // sw is asynchronous to clk, so it is brought in through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1     <= 1'b0;
            s_sync <= 1'b0;
        end else begin
            s1     <= sw;
            s_sync <= s1;
        end
    end

    // A level change is accepted only after N_TICKS ticks with s_sync stable;
    // a change of s_sync always wins over a simultaneous tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
            db_tick  <= 1'b0;
`ifdef STEP_DEBOUNCER_FALL_EN
            db_fall_tick <= 1'b0;
`endif
        end else begin
            db_tick <= 1'b0;
`ifdef STEP_DEBOUNCER_FALL_EN
            db_fall_tick <= 1'b0;
`endif
            case (state)
                ZERO: begin
                    if (s_sync) begin
                        state <= WAIT1;
                        cnt   <= '0;
                    end
                end
                WAIT1: begin
                    if (!s_sync) begin
                        state <= ZERO;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == LAST) begin
                            state    <= ONE;
                            cnt      <= '0;
                            db_level <= 1'b1;
                            db_tick  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ONE: begin
                    if (!s_sync) begin
                        state <= WAIT0;
                        cnt   <= '0;
                    end
                end
                WAIT0: begin
                    if (s_sync) begin
                        state <= ONE;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == LAST) begin
                            state    <= ZERO;
                            cnt      <= '0;
                            db_level <= 1'b0;
`ifdef STEP_DEBOUNCER_FALL_EN
                            db_fall_tick <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ZERO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_debouncer.sv
// Directed bench for step_debouncer: one instance with N_TICKS=3, one with N_TICKS=1.
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
module tb_step_debouncer;

    logic clk;
    logic reset;
    logic tick3, sw3, tick1, sw1;
    logic db_level3, db_tick3, db_level1, db_tick1;
`ifdef STEP_DEBOUNCER_FALL_EN
    logic db_fall_tick3, db_fall_tick1;
`endif

    int checks;
    int failures;

    step_debouncer #(.N_TICKS(3), .CW(8)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick3),
        .sw      (sw3),
        .db_level(db_level3),
`ifdef STEP_DEBOUNCER_FALL_EN
        .db_fall_tick(db_fall_tick3),
`endif
        .db_tick (db_tick3)
    );

    step_debouncer #(.N_TICKS(1), .CW(8)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick1),
        .sw      (sw1),
        .db_level(db_level1),
`ifdef STEP_DEBOUNCER_FALL_EN
        .db_fall_tick(db_fall_tick1),
`endif
        .db_tick (db_tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step3(input logic t, input logic s);
        tick3 = t;
        sw3   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic t, input logic s);
        tick1 = t;
        sw1   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick3 = 1'b0; sw3 = 1'b0;
        tick1 = 1'b0; sw1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step3(k % 5 == 4, 1'b1);
            checks++;
            if (db_level3 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold_level k=%0d got %b expected 0", k, db_level3);
            end
            checks++;
            if (db_tick3 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold_tick k=%0d got %b expected 0", k, db_tick3);
            end
        end
        reset = 1'b1;
        for (int k = 0; k < 35; k++) begin
            step3(k % 10 == 9, 1'b1);
            checks++;
            if (db_level3 !== (k >= 29)) begin
                failures++;
                $display("[TB] FAIL reset_release_level k=%0d got %b expected %b", k, db_level3, k >= 29);
            end
            checks++;
            if (db_tick3 !== (k == 29)) begin
                failures++;
                $display("[TB] FAIL reset_release_tick k=%0d got %b expected %b", k, db_tick3, k == 29);
            end
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int k = 0; k < 80; k++) begin
            step3(k % 10 == 9, (k >= 40) ? 1'b1 : (((k / 4) % 2) == 0));
            checks++;
            if (db_tick3 !== (k == 69)) begin
                failures++;
                $display("[TB] FAIL bounce_tick k=%0d got %b expected %b", k, db_tick3, k == 69);
            end
            checks++;
            if (db_level3 !== (k >= 69)) begin
                failures++;
                $display("[TB] FAIL bounce_level k=%0d got %b expected %b", k, db_level3, k >= 69);
            end
        end
    endtask

    // Continues from the ONE state left by test_bounce.
    task automatic test_release();
        for (int j = 0; j < 35; j++) begin
            step3(j % 10 == 9, 1'b0);
            checks++;
            if (db_level3 !== (j < 29)) begin
                failures++;
                $display("[TB] FAIL release_level j=%0d got %b expected %b", j, db_level3, j < 29);
            end
            checks++;
            if (db_tick3 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL release_tick j=%0d got %b expected 0", j, db_tick3);
            end
`ifdef STEP_DEBOUNCER_FALL_EN
            checks++;
            if (db_fall_tick3 !== (j == 29)) begin
                failures++;
                $display("[TB] FAIL release_fall_tick j=%0d got %b expected %b", j, db_fall_tick3, j == 29);
            end
`endif
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int j = 0; j < 41; j++) begin
            step3(j % 10 == 9, j < 27);
            checks++;
            if (db_level3 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL simult_level j=%0d got %b expected 0", j, db_level3);
            end
            checks++;
            if (db_tick3 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL simult_tick j=%0d got %b expected 0", j, db_tick3);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 32; k++) step3(k % 10 == 9, 1'b1);
        checks++;
        if (db_level3 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_pre_level got %b expected 1", db_level3);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (db_level3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_async_level_one got %b expected 0", db_level3);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 12; k++) step3(k % 10 == 9, 1'b1);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({db_level3, db_tick3} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL mid_async_wait1 got %b expected 00", {db_level3, db_tick3});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 35; k++) begin
            step3(k % 10 == 9, 1'b1);
            checks++;
            if (db_level3 !== (k >= 29)) begin
                failures++;
                $display("[TB] FAIL mid_restart_level k=%0d got %b expected %b", k, db_level3, k >= 29);
            end
            checks++;
            if (db_tick3 !== (k == 29)) begin
                failures++;
                $display("[TB] FAIL mid_restart_tick k=%0d got %b expected %b", k, db_tick3, k == 29);
            end
        end
    endtask

    task automatic test_single_tick();
        apply_reset();
        for (int j = 0; j < 12; j++) begin
            step1(1'b1, 1'b1);
            checks++;
            if (db_tick1 !== (j == 3)) begin
                failures++;
                $display("[TB] FAIL n1_steady_tick j=%0d got %b expected %b", j, db_tick1, j == 3);
            end
            checks++;
            if (db_level1 !== (j >= 3)) begin
                failures++;
                $display("[TB] FAIL n1_steady_level j=%0d got %b expected %b", j, db_level1, j >= 3);
            end
        end
    endtask

    task automatic test_glitch();
        // One-clock glitch: s_sync drops before any tick can be honoured.
        apply_reset();
        for (int j = 0; j < 20; j++) begin
            step1(j % 10 == 3, j == 0);
            checks++;
            if ({db_level1, db_tick1} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL glitch1_out j=%0d got %b expected 00", j, {db_level1, db_tick1});
            end
        end
        // Two-clock glitch with a tick while still high: accepted, then released.
        apply_reset();
        for (int j = 0; j < 20; j++) begin
            step1(j % 10 == 3, j < 2);
            checks++;
            if (db_level1 !== (j >= 3 && j < 13)) begin
                failures++;
                $display("[TB] FAIL glitch2_level j=%0d got %b expected %b", j, db_level1, j >= 3 && j < 13);
            end
            checks++;
            if (db_tick1 !== (j == 3)) begin
                failures++;
                $display("[TB] FAIL glitch2_tick j=%0d got %b expected %b", j, db_tick1, j == 3);
            end
`ifdef STEP_DEBOUNCER_FALL_EN
            checks++;
            if (db_fall_tick1 !== (j == 13)) begin
                failures++;
                $display("[TB] FAIL glitch2_fall j=%0d got %b expected %b", j, db_fall_tick1, j == 13);
            end
`endif
        end
        // Two-clock glitch that falls before any tick: ignored.
        apply_reset();
        for (int j = 0; j < 20; j++) begin
            step1(j % 10 == 5, j < 2);
            checks++;
            if ({db_level1, db_tick1} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL glitch3_out j=%0d got %b expected 00", j, {db_level1, db_tick1});
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        tick3 = 1'b0; sw3 = 1'b0;
        tick1 = 1'b0; sw1 = 1'b0;
        $display("[TB] starting step_debouncer tests");
        test_reset();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_single_tick();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
